// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32 divide/remainder sequencer: a restoring shift-subtract divider
// that performs every arithmetic step on the shared core ALU.
`timescale 1ns/1ps
module alu_div_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            is_signed,
   input  logic            want_rem,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_in_0,
   output logic [XLEN-1:0] alu_in_1,
   output logic [3:0]      alu_operation,
   input  logic [XLEN-1:0] alu_out
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_LTU = 4'd3;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE} state_t;

   state_t            state_reg;
   logic [XLEN-1:0]   q_reg;
   logic [XLEN-1:0]   r_reg;
   logic [XLEN-1:0]   d_reg;
   logic [XLEN-1:0]   result_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              ge_reg;
   logic              neg_a_reg;
   logic              neg_b_reg;
   logic              want_rem_reg;
   logic              busy_reg;
   logic              done_reg;

   logic [XLEN-1:0]   s_val;
   logic [XLEN-1:0]   fix_val;
   logic              fix_neg;

   // Partial remainder shifted left with the next dividend bit; R[XLEN-1] is the 33rd bit.
   assign s_val   = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
   assign fix_val = want_rem_reg ? r_reg : q_reg;
   assign fix_neg = want_rem_reg ? neg_a_reg : (neg_a_reg ^ neg_b_reg);

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;

   always_comb begin
      alu_operation = ALU_ADD;
      alu_in_0      = '0;
      alu_in_1      = '0;
      case (state_reg)
         NEG_A: begin
            alu_operation = ALU_SUB;
            alu_in_1      = q_reg;
         end
         NEG_B: begin
            alu_operation = ALU_SUB;
            alu_in_1      = d_reg;
         end
         CMP: begin
            alu_operation = ALU_LTU;
            alu_in_0      = s_val;
            alu_in_1      = d_reg;
         end
         SUB: begin
            alu_operation = ALU_SUB;
            alu_in_0      = s_val;
            alu_in_1      = d_reg;
         end
         FIX: begin
            alu_operation = ALU_SUB;
            alu_in_1      = fix_val;
         end
         default: begin
            alu_operation = ALU_ADD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         q_reg        <= '0;
         r_reg        <= '0;
         d_reg        <= '0;
         result_reg   <= '0;
         cnt_reg      <= '0;
         ge_reg       <= 1'b0;
         neg_a_reg    <= 1'b0;
         neg_b_reg    <= 1'b0;
         want_rem_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  neg_a_reg    <= is_signed & dividend[XLEN-1];
                  neg_b_reg    <= is_signed & divisor[XLEN-1];
                  want_rem_reg <= want_rem;
                  q_reg        <= dividend;
                  d_reg        <= divisor;
                  if (divisor == '0) begin
                     result_reg <= want_rem ? dividend : ALL_ONES;
                     done_reg   <= 1'b1;
                     state_reg  <= DONE;
                  end else if (is_signed && dividend == MIN_NEG && divisor == ALL_ONES) begin
                     result_reg <= want_rem ? '0 : MIN_NEG;
                     done_reg   <= 1'b1;
                     state_reg  <= DONE;
                  end else begin
                     busy_reg  <= 1'b1;
                     state_reg <= NEG_A;
                  end
               end
            end
            NEG_A: begin
               q_reg     <= neg_a_reg ? alu_out : q_reg;
               state_reg <= NEG_B;
            end
            NEG_B: begin
               d_reg     <= neg_b_reg ? alu_out : d_reg;
               r_reg     <= '0;
               cnt_reg   <= CNT_W'(XLEN - 1);
               state_reg <= CMP;
            end
            CMP: begin
               // A set shifted-out bit means S exceeds any XLEN-bit divisor.
               ge_reg    <= r_reg[XLEN-1] | ~alu_out[0];
               state_reg <= SUB;
            end
            SUB: begin
               r_reg <= ge_reg ? alu_out : s_val;
               q_reg <= {q_reg[XLEN-2:0], ge_reg};
               if (cnt_reg == '0) begin
                  state_reg <= FIX;
               end else begin
                  cnt_reg   <= cnt_reg - CNT_W'(1);
                  state_reg <= CMP;
               end
            end
            FIX: begin
               result_reg <= fix_neg ? alu_out : fix_val;
               busy_reg   <= 1'b0;
               done_reg   <= 1'b1;
               state_reg  <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
